regfile_debug_arbiter: RTL and testbench

Shares the processor register file between the pipeline and the UART debug agent. In normal running it passes the pipeline's decode read addresses and writeback write port straight through. When the debug agent issues a request, the block freezes the pipeline through a stall handshake and then takes ownership of the register file. It performs a single-register read, a single-register write, or a 32-register dump, returns the results over a valid/ready response channel, and then releases the pipeline.

---
 rtl/regfile_dbg_pkg.sv | 34 +++
 rtl/regfile_port_mux.sv | 40 ++++
 rtl/regfile_debug_arbiter.sv | 154 +++++++++++++++
 tb/tb_regfile_debug_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_dbg_pkg.sv
// Shared definitions for the register-file debug arbiter: op codes, FSM states
// and register-file geometry.
package regfile_dbg_pkg;

    localparam int unsigned REG_COUNT = 32;
    localparam int unsigned LAST_REG  = 31;

    typedef enum logic [1:0] {
        OP_READ  = 2'b00,
        OP_WRITE = 2'b01,
        OP_DUMP  = 2'b10,
        OP_RSVD  = 2'b11
    } dbg_op_e;

    typedef enum logic [2:0] {
        IDLE,
        DRAIN,
        ACCESS,
        RESP,
        RELEASE
    } dbg_state_e;

    // Reserved op code behaves as a single-register read.
    function automatic dbg_op_e normalize_op(input logic [1:0] raw);
        dbg_op_e op;
        case (raw)
            2'b01:   op = OP_WRITE;
            2'b10:   op = OP_DUMP;
            default: op = OP_READ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/regfile_port_mux.sv
// Selects whether the pipeline or the debug agent drives the register-file
// read/write ports.
module regfile_port_mux #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  dbg_owner,
    input  logic [ADDR_WIDTH-1:0] id_read_reg1,
    input  logic [ADDR_WIDTH-1:0] id_read_reg2,
    input  logic                  pipe_reg_write,
    input  logic [ADDR_WIDTH-1:0] wb_rt_rd,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    input  logic [ADDR_WIDTH-1:0] dbg_read_reg,
    input  logic                  dbg_reg_write,
    input  logic [ADDR_WIDTH-1:0] dbg_write_addr,
    input  logic [DATA_WIDTH-1:0] dbg_write_data,
    output logic [ADDR_WIDTH-1:0] rf_read_reg1,
    output logic [ADDR_WIDTH-1:0] rf_read_reg2,
    output logic                  rf_reg_write,
    output logic [ADDR_WIDTH-1:0] rf_rt_rd,
    output logic [DATA_WIDTH-1:0] rf_write_data
);

    always_comb begin
        if (dbg_owner) begin
            rf_read_reg1  = dbg_read_reg;
            rf_read_reg2  = '0;
            rf_reg_write  = dbg_reg_write;
            rf_rt_rd      = dbg_write_addr;
            rf_write_data = dbg_write_data;
        end else begin
            rf_read_reg1  = id_read_reg1;
            rf_read_reg2  = id_read_reg2;
            rf_reg_write  = pipe_reg_write;
            rf_rt_rd      = wb_rt_rd;
            rf_write_data = wb_write_data;
        end
    end

endmodule

// File: rtl/regfile_debug_arbiter.sv
// Arbitrates the register file between the pipeline and the UART debug agent,
// stalling the pipeline for debug reads, writes and full-register dumps.
module regfile_debug_arbiter
    import regfile_dbg_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] id_read_reg1,
    input  logic [ADDR_WIDTH-1:0] id_read_reg2,
    input  logic                  wb_reg_write,
    input  logic [ADDR_WIDTH-1:0] wb_rt_rd,
    input  logic [DATA_WIDTH-1:0] wb_write_data,
    output logic [ADDR_WIDTH-1:0] rf_read_reg1,
    output logic [ADDR_WIDTH-1:0] rf_read_reg2,
    output logic                  rf_reg_write,
    output logic [ADDR_WIDTH-1:0] rf_rt_rd,
    output logic [DATA_WIDTH-1:0] rf_write_data,
    input  logic [DATA_WIDTH-1:0] rf_reg1_data,
    input  logic                  dbg_req_valid,
    output logic                  dbg_req_ready,
    input  logic [1:0]            dbg_req_op,
    input  logic [ADDR_WIDTH-1:0] dbg_req_addr,
    input  logic [DATA_WIDTH-1:0] dbg_req_data,
    output logic                  dbg_rsp_valid,
    input  logic                  dbg_rsp_ready,
    output logic [ADDR_WIDTH-1:0] dbg_rsp_addr,
    output logic [DATA_WIDTH-1:0] dbg_rsp_data,
    output logic                  dbg_rsp_last,
    output logic                  stall_req,
    input  logic                  stall_ack,
    output logic                  busy,
    output logic                  err_wb_drop
);

    dbg_state_e            state_q, state_d;
    dbg_op_e               req_op_q;
    logic [ADDR_WIDTH-1:0] req_addr_q;
    logic [DATA_WIDTH-1:0] req_data_q;
    logic [ADDR_WIDTH-1:0] beat_q;
    logic [ADDR_WIDTH-1:0] rsp_addr_q;
    logic [DATA_WIDTH-1:0] rsp_data_q;
    logic                  rsp_last_q;
    logic                  err_q;
    logic                  stall_q;

    logic                  accept;
    logic                  rsp_fire;
    logic                  more_beats;
    logic                  stall_next;
    logic                  dbg_owner;
    logic                  pipe_wr_allow;
    logic                  dbg_wr_en;
    logic [ADDR_WIDTH-1:0] target;

    assign accept     = dbg_req_valid & dbg_req_ready;
    assign rsp_fire   = dbg_rsp_valid & dbg_rsp_ready;
    assign more_beats = (req_op_q == OP_DUMP) && (beat_q != ADDR_WIDTH'(LAST_REG));
    assign target     = (req_op_q == OP_DUMP) ? beat_q : req_addr_q;
    assign stall_next = (state_d == DRAIN) || (state_d == ACCESS) || (state_d == RESP);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept)        state_d = DRAIN;
            DRAIN:   if (stall_ack)     state_d = ACCESS;
            ACCESS:                     state_d = RESP;
            RESP:    if (dbg_rsp_ready) state_d = more_beats ? ACCESS : RELEASE;
            RELEASE: if (!stall_ack)    state_d = IDLE;
            default:                    state_d = IDLE;
        endcase
    end

    // Ready is masked by reset so every output reads 0 while reset is held.
    always_comb begin
        dbg_req_ready = (state_q == IDLE) && !reset;
        dbg_rsp_valid = (state_q == RESP);
        busy          = (state_q != IDLE);
        dbg_owner     = (state_q == ACCESS);
        pipe_wr_allow = (state_q == IDLE) || (state_q == DRAIN);
        dbg_wr_en     = (state_q == ACCESS) && (req_op_q == OP_WRITE);
    end

    // stall_req comes straight from a flop so the pipeline never sees a glitch.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_op_q   <= OP_READ;
            req_addr_q <= '0;
            req_data_q <= '0;
            beat_q     <= '0;
            rsp_addr_q <= '0;
            rsp_data_q <= '0;
            rsp_last_q <= 1'b0;
            err_q      <= 1'b0;
            stall_q    <= 1'b0;
        end else begin
            if (accept) begin
                req_op_q   <= normalize_op(dbg_req_op);
                req_addr_q <= dbg_req_addr;
                req_data_q <= dbg_req_data;
                beat_q     <= '0;
            end else if (rsp_fire && more_beats) begin
                beat_q <= beat_q + 1'b1;
            end
            if (state_q == ACCESS) begin
                rsp_addr_q <= target;
                rsp_data_q <= (req_op_q == OP_WRITE) ? req_data_q : rf_reg1_data;
                rsp_last_q <= (req_op_q != OP_DUMP) || (beat_q == ADDR_WIDTH'(LAST_REG));
            end
            if (wb_reg_write && !pipe_wr_allow) begin
                err_q <= 1'b1;
            end
            stall_q <= stall_next;
        end
    end

    assign stall_req    = stall_q;
    assign err_wb_drop  = err_q;
    assign dbg_rsp_addr = rsp_addr_q;
    assign dbg_rsp_data = rsp_data_q;
    assign dbg_rsp_last = rsp_last_q;

    regfile_port_mux #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_port_mux (
        .dbg_owner      (dbg_owner),
        .id_read_reg1   (id_read_reg1),
        .id_read_reg2   (id_read_reg2),
        .pipe_reg_write (wb_reg_write & pipe_wr_allow),
        .wb_rt_rd       (wb_rt_rd),
        .wb_write_data  (wb_write_data),
        .dbg_read_reg   (target),
        .dbg_reg_write  (dbg_wr_en),
        .dbg_write_addr (req_addr_q),
        .dbg_write_data (req_data_q),
        .rf_read_reg1   (rf_read_reg1),
        .rf_read_reg2   (rf_read_reg2),
        .rf_reg_write   (rf_reg_write),
        .rf_rt_rd       (rf_rt_rd),
        .rf_write_data  (rf_write_data)
    );

endmodule

// File: tb/tb_regfile_debug_arbiter.sv
// Scoreboard bench for regfile_debug_arbiter with a behavioural register file
// and a stall-acknowledging pipeline model.
module tb_regfile_debug_arbiter;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  id_read_reg1 = '0;
    logic [4:0]  id_read_reg2 = '0;
    logic        wb_reg_write = 1'b0;
    logic [4:0]  wb_rt_rd = '0;
    logic [31:0] wb_write_data = '0;
    logic [4:0]  rf_read_reg1, rf_read_reg2, rf_rt_rd;
    logic        rf_reg_write;
    logic [31:0] rf_write_data, rf_reg1_data;
    logic        dbg_req_valid = 1'b0;
    logic        dbg_req_ready;
    logic [1:0]  dbg_req_op = '0;
    logic [4:0]  dbg_req_addr = '0;
    logic [31:0] dbg_req_data = '0;
    logic        dbg_rsp_valid;
    logic        dbg_rsp_ready;
    logic [4:0]  dbg_rsp_addr;
    logic [31:0] dbg_rsp_data;
    logic        dbg_rsp_last;
    logic        stall_req, stall_ack, busy, err_wb_drop;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t       sb[$];
    int          errors = 0;
    int          checks = 0;
    int          beats_seen = 0;
    int          stall_hi = 0;
    int unsigned ack_delay = 0;
    logic        rsp_toggle = 1'b0;
    logic [7:0]  stall_cycles = '0;
    logic [31:0] rf_mem [32];

    regfile_debug_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
        .clock(clock), .reset(reset),
        .id_read_reg1(id_read_reg1), .id_read_reg2(id_read_reg2),
        .wb_reg_write(wb_reg_write), .wb_rt_rd(wb_rt_rd), .wb_write_data(wb_write_data),
        .rf_read_reg1(rf_read_reg1), .rf_read_reg2(rf_read_reg2),
        .rf_reg_write(rf_reg_write), .rf_rt_rd(rf_rt_rd), .rf_write_data(rf_write_data),
        .rf_reg1_data(rf_reg1_data),
        .dbg_req_valid(dbg_req_valid), .dbg_req_ready(dbg_req_ready),
        .dbg_req_op(dbg_req_op), .dbg_req_addr(dbg_req_addr), .dbg_req_data(dbg_req_data),
        .dbg_rsp_valid(dbg_rsp_valid), .dbg_rsp_ready(dbg_rsp_ready),
        .dbg_rsp_addr(dbg_rsp_addr), .dbg_rsp_data(dbg_rsp_data), .dbg_rsp_last(dbg_rsp_last),
        .stall_req(stall_req), .stall_ack(stall_ack),
        .busy(busy), .err_wb_drop(err_wb_drop)
    );

    always #5 clock = ~clock;

    // Register file: register 0 is hardwired to zero.
    assign rf_reg1_data = (rf_read_reg1 == 5'd0) ? 32'd0 : rf_mem[rf_read_reg1];
    always @(posedge clock) begin
        if (rf_reg_write && rf_rt_rd != 5'd0) rf_mem[rf_rt_rd] <= rf_write_data;
    end

    // Pipeline acknowledges a stall after ack_delay cycles, drops it at once.
    always @(posedge clock) begin
        if (stall_req) stall_cycles <= (stall_cycles == 8'hFF) ? stall_cycles : stall_cycles + 8'd1;
        else           stall_cycles <= '0;
    end
    assign stall_ack = stall_req && (32'(stall_cycles) >= ack_delay);

    always @(negedge clock) if (stall_req) stall_hi++;

    initial begin
        dbg_rsp_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            dbg_rsp_ready = rsp_toggle ? ~dbg_rsp_ready : 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Monitor: every accepted response beat is compared with the queue head.
    always @(negedge clock) begin
        if (!reset && dbg_rsp_valid && dbg_rsp_ready) begin
            beats_seen++;
            if (sb.size() == 0) begin
                chk("unexpected_beat", {27'd0, dbg_rsp_addr, dbg_rsp_data}, 64'd0);
            end else begin
                beat_t e;
                e = sb.pop_front();
                chk("rsp_beat", {26'd0, dbg_rsp_addr, dbg_rsp_last, dbg_rsp_data},
                    {26'd0, e.addr, e.last, e.data});
            end
        end
    end

    task automatic expect_beat(input logic [4:0] a, input logic [31:0] d, input logic l);
        beat_t b;
        b.addr = a; b.data = d; b.last = l;
        sb.push_back(b);
    endtask

    task automatic pipe_write(input logic [4:0] a, input logic [31:0] d);
        @(negedge clock);
        wb_reg_write = 1'b1; wb_rt_rd = a; wb_write_data = d;
        @(negedge clock);
        wb_reg_write = 1'b0;
    endtask

    // Returns on the negedge after acceptance (the DUT is then in DRAIN).
    task automatic issue(input logic [1:0] op, input logic [4:0] a, input logic [31:0] d);
        int unsigned n = 0;
        @(negedge clock);
        while (!dbg_req_ready && n < 300) begin
            @(negedge clock);
            n++;
        end
        if (!dbg_req_ready) chk("req_ready_timeout", 64'(dbg_req_ready), 64'd1);
        dbg_req_valid = 1'b1; dbg_req_op = op; dbg_req_addr = a; dbg_req_data = d;
        @(negedge clock);
        dbg_req_valid = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int unsigned n = 0;
        while ((busy || sb.size() != 0) && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk(nm, {31'd0, busy, 32'(sb.size())}, 64'd0);
    endtask

    initial begin
        int base;
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        repeat (2) @(negedge clock);
        chk("reset_outputs", {59'd0, dbg_rsp_valid, stall_req, busy, err_wb_drop, dbg_req_ready}, 64'd0);
        chk("reset_rsp_fields", {26'd0, dbg_rsp_addr, dbg_rsp_last, dbg_rsp_data}, 64'd0);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_ready", 64'(dbg_req_ready), 64'd1);

        // Single read with immediate stall acknowledge.
        pipe_write(5'd5, 32'h1234_5678);
        base = stall_hi;
        expect_beat(5'd5, 32'h1234_5678, 1'b1);
        issue(2'b00, 5'd5, 32'd0);
        wait_done("read5_done");
        chk("read5_stall_cycles", 64'(stall_hi - base), 64'd3);

        // Write then read back, plus a write to register 0.
        expect_beat(5'd9, 32'hCAFE_F00D, 1'b1);
        issue(2'b01, 5'd9, 32'hCAFE_F00D);
        wait_done("write9_done");
        expect_beat(5'd9, 32'hCAFE_F00D, 1'b1);
        issue(2'b00, 5'd9, 32'd0);
        wait_done("read9_done");
        expect_beat(5'd0, 32'hABCD_0000, 1'b1);
        issue(2'b01, 5'd0, 32'hABCD_0000);
        wait_done("write0_done");

        // Dump under backpressure.
        for (int i = 1; i < 32; i++) pipe_write(5'(i), 32'(i * 3));
        rsp_toggle = 1'b1;
        for (int i = 0; i < 32; i++) expect_beat(5'(i), 32'(i * 3), i == 31);
        issue(2'b10, 5'd0, 32'd0);
        wait_done("dump_done");
        rsp_toggle = 1'b0;

        // Reserved op behaves as read.
        expect_beat(5'd5, 32'd15, 1'b1);
        issue(2'b11, 5'd5, 32'hFFFF_FFFF);
        wait_done("op11_done");

        // Slow acknowledge; pipeline writeback during DRAIN must land.
        ack_delay = 10;
        expect_beat(5'd4, 32'h77, 1'b1);
        issue(2'b00, 5'd4, 32'd0);
        wb_reg_write = 1'b1; wb_rt_rd = 5'd4; wb_write_data = 32'h77;
        @(negedge clock);
        wb_reg_write = 1'b0;
        wait_done("drain_wb_done");
        ack_delay = 0;
        expect_beat(5'd4, 32'h77, 1'b1);
        issue(2'b00, 5'd4, 32'd0);
        wait_done("read4_done");
        chk("no_drop_in_drain", 64'(err_wb_drop), 64'd0);

        // Pipeline writeback during ACCESS is dropped and flagged.
        expect_beat(5'd7, 32'd21, 1'b1);
        issue(2'b00, 5'd7, 32'd0);
        @(negedge clock);
        wb_reg_write = 1'b1; wb_rt_rd = 5'd7; wb_write_data = 32'hDEAD;
        @(negedge clock);
        wb_reg_write = 1'b0;
        wait_done("access_wb_done");
        chk("err_wb_drop_set", 64'(err_wb_drop), 64'd1);
        expect_beat(5'd7, 32'd21, 1'b1);
        issue(2'b00, 5'd7, 32'd0);
        wait_done("read7_done");
        chk("err_wb_drop_sticky", 64'(err_wb_drop), 64'd1);

        // Reset in the middle of a dump at beat 12.
        for (int i = 0; i < 32; i++) expect_beat(5'(i), (i == 4) ? 32'h77 : 32'(i * 3), i == 31);
        base = beats_seen;
        issue(2'b10, 5'd0, 32'd0);
        for (int n = 0; n < 200 && (beats_seen - base) < 12; n++) @(negedge clock);
        chk("beats_before_reset", 64'(beats_seen - base), 64'd12);
        @(posedge clock);
        #2 reset = 1'b1;
        #1;
        chk("async_reset_outputs",
            {58'd0, dbg_rsp_valid, stall_req, busy, err_wb_drop, dbg_req_ready, rf_reg_write}, 64'd0);
        sb.delete();
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        chk("post_reset_ready", 64'(dbg_req_ready), 64'd1);
        expect_beat(5'd12, 32'd36, 1'b1);
        issue(2'b00, 5'd12, 32'd0);
        wait_done("post_reset_read");

        repeat (3) @(negedge clock);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
